// File: rtl/reg_port_sequencer.sv
// Operand-fetch sequencer for the single-port register bank: fetches rs1/rs2 with
// sequential port reads, hands operands to execute, and yields the port to writeback.
module reg_port_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [REG_ADDR_WIDTH-1:0] req_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] req_rs2,
    input  logic                      req_use_rs2,
    output logic                      op_valid,
    input  logic                      op_ready,
    output logic [DATA_WIDTH-1:0]     op_rs1_data,
    output logic [DATA_WIDTH-1:0]     op_rs2_data,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic [REG_ADDR_WIDTH-1:0] rb_reg_num,
    output logic                      rb_write_en,
    output logic [DATA_WIDTH-1:0]     rb_data_in,
    input  logic [DATA_WIDTH-1:0]     rb_data_out
);

    typedef enum logic [1:0] {IDLE, READ1, READ2, HOLD} state_e;

    state_e                    state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic                      use_rs2_q, use_rs2_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q, rs2_data_d;

    logic wb_active;
    logic wb_fwd;
    logic accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            use_rs2_q  <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            use_rs2_q  <= use_rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_rs2_d   = use_rs2_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rb_reg_num  = '0;
        rb_write_en = 1'b0;
        rb_data_in  = '0;

        req_ready = (state_q == IDLE) || ((state_q == HOLD) && op_ready);
        accept    = req_valid && req_ready;
        wb_active = wb_valid && !reset;
        wb_fwd    = wb_active && (wb_rd != '0);

        // Writeback owns the port whenever present; operand reads stall behind it.
        if (wb_active) begin
            rb_reg_num  = wb_rd;
            rb_write_en = 1'b1;
            rb_data_in  = wb_data;
        end else if (state_q == READ1) begin
            rb_reg_num = rs1_q;
        end else if (state_q == READ2) begin
            rb_reg_num = rs2_q;
        end

        case (state_q)
            READ1: begin
                if (!wb_active) begin
                    rs1_data_d = rb_data_out;
                    state_d    = (use_rs2_q && (rs2_q != '0)) ? READ2 : HOLD;
                end
            end
            READ2: begin
                if (!wb_active) begin
                    rs2_data_d = rb_data_out;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (op_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Keep already-captured operands coherent with writes landing after their read.
        if (wb_fwd && ((state_q == READ2) || (state_q == HOLD)) && (wb_rd == rs1_q))
            rs1_data_d = wb_data;
        if (wb_fwd && (state_q == HOLD) && use_rs2_q && (wb_rd == rs2_q))
            rs2_data_d = wb_data;

        // Skipped reads leave their operand at zero; pending reads overwrite it later.
        if (accept) begin
            rs1_d      = req_rs1;
            rs2_d      = req_rs2;
            use_rs2_d  = req_use_rs2;
            rs1_data_d = '0;
            rs2_data_d = '0;
            if (req_rs1 != '0)
                state_d = READ1;
            else if (req_use_rs2 && (req_rs2 != '0))
                state_d = READ2;
            else
                state_d = HOLD;
        end
    end

    assign op_valid    = (state_q == HOLD);
    assign op_rs1_data = rs1_data_q;
    assign op_rs2_data = rs2_data_q;
    assign wb_ready    = !reset;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed bench for reg_port_sequencer with a behavioural 16x32 single-port bank attached.
module tb_reg_port_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_use_rs2;
    logic [3:0]  req_rs1, req_rs2;
    logic        op_valid, op_ready;
    logic [31:0] op_rs1_data, op_rs2_data;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  rb_reg_num;
    logic        rb_write_en;
    logic [31:0] rb_data_in, rb_data_out;

    logic [31:0] bank [16];
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_port_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_rs2(req_use_rs2),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rb_reg_num(rb_reg_num), .rb_write_en(rb_write_en),
        .rb_data_in(rb_data_in), .rb_data_out(rb_data_out)
    );

    // Bank: synchronous write, combinational read, x0 reads zero.
    always @(posedge clk) if (rb_write_en) bank[rb_reg_num] <= rb_data_in;
    assign rb_data_out = (rb_reg_num == 4'd0) ? 32'd0 : bank[rb_reg_num];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] r1, input logic [3:0] r2, input logic use2);
        req_valid = 1'b1; req_rs1 = r1; req_rs2 = r2; req_use_rs2 = use2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 32'd0;
        reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_use_rs2 = 1'b0;
        op_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        tick; tick;
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_rs1", op_rs1_data, 32'd0);
        chk("rst_rs2", op_rs2_data, 32'd0);
        chk("rst_rb_reg", 32'(rb_reg_num), 32'd0);
        reset = 1'b0;
        tick;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_wb_ready", 32'(wb_ready), 32'd1);

        // Preload x5, x7 through the writeback path
        wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 32'hA5A5_0005; #1;
        chk("wb_mux_en", 32'(rb_write_en), 32'd1);
        chk("wb_mux_reg", 32'(rb_reg_num), 32'd5);
        tick;
        wb_rd = 4'd7; wb_data = 32'h0000_0777;
        tick;
        wb_valid = 1'b0;

        // Test 1: two reads, op_valid on the third edge counting the accept edge
        request(4'd5, 4'd7, 1'b1); #1;
        chk("t1_req_ready", 32'(req_ready), 32'd1);
        tick; req_valid = 1'b0; #1;
        chk("t1_c1_valid", 32'(op_valid), 32'd0);
        chk("t1_c1_reg", 32'(rb_reg_num), 32'd5);
        tick;
        chk("t1_c2_valid", 32'(op_valid), 32'd0);
        chk("t1_c2_reg", 32'(rb_reg_num), 32'd7);
        tick;
        chk("t1_valid", 32'(op_valid), 32'd1);
        chk("t1_rs1", op_rs1_data, 32'hA5A5_0005);
        chk("t1_rs2", op_rs2_data, 32'h0000_0777);
        op_ready = 1'b1; tick; op_ready = 1'b0; #1;
        chk("t1_release", 32'(op_valid), 32'd0);

        // Test 2: both indices zero, no port cycles
        request(4'd0, 4'd0, 1'b1); #1;
        chk("t2_we_acc", 32'(rb_write_en), 32'd0);
        tick; req_valid = 1'b0; #1;
        chk("t2_valid", 32'(op_valid), 32'd1);
        chk("t2_rs1", op_rs1_data, 32'd0);
        chk("t2_rs2", op_rs2_data, 32'd0);
        chk("t2_we_hold", 32'(rb_write_en), 32'd0);
        op_ready = 1'b1; tick; op_ready = 1'b0;

        // Test 3: writeback stalls READ1 for two cycles
        request(4'd3, 4'd0, 1'b0);
        tick; req_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h0000_1234; #1;
        chk("t3_wb_reg", 32'(rb_reg_num), 32'd3);
        chk("t3_wb_en", 32'(rb_write_en), 32'd1);
        tick;
        chk("t3_stall1", 32'(op_valid), 32'd0);
        tick; wb_valid = 1'b0; #1;
        chk("t3_stall2", 32'(op_valid), 32'd0);
        chk("t3_read_en", 32'(rb_write_en), 32'd0);
        chk("t3_read_reg", 32'(rb_reg_num), 32'd3);
        tick;
        chk("t3_valid", 32'(op_valid), 32'd1);
        chk("t3_rs1", op_rs1_data, 32'h0000_1234);
        chk("t3_rs2", op_rs2_data, 32'd0);
        chk("t3_bank", bank[3], 32'h0000_1234);

        // Test 4: back-to-back accept from HOLD, then forwarding into captured rs1
        op_ready = 1'b1; request(4'd4, 4'd0, 1'b0); #1;
        chk("t4_req_ready", 32'(req_ready), 32'd1);
        tick; op_ready = 1'b0; req_valid = 1'b0; #1;
        chk("t4_drop", 32'(op_valid), 32'd0);
        tick;
        chk("t4_valid", 32'(op_valid), 32'd1);
        chk("t4_rs1_pre", op_rs1_data, 32'd0);
        wb_valid = 1'b1; wb_rd = 4'd4; wb_data = 32'h0000_DEAD;
        tick;
        chk("t4_fwd", op_rs1_data, 32'h0000_DEAD);
        wb_rd = 4'd0; wb_data = 32'h0000_FFFF;
        tick; wb_valid = 1'b0; #1;
        chk("t4_x0_rs1", op_rs1_data, 32'h0000_DEAD);
        chk("t4_x0_rs2", op_rs2_data, 32'd0);

        // Test 5: stable hold under backpressure, then accept with rs1 == rs2
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t5_hold_valid", 32'(op_valid), 32'd1);
            chk("t5_hold_rs1", op_rs1_data, 32'h0000_DEAD);
        end
        op_ready = 1'b1; request(4'd5, 4'd5, 1'b1); #1;
        chk("t5_req_ready", 32'(req_ready), 32'd1);
        tick; op_ready = 1'b0; req_valid = 1'b0; #1;
        chk("t5_drop", 32'(op_valid), 32'd0);
        tick; tick;
        chk("t5_valid", 32'(op_valid), 32'd1);
        chk("t5_rs1", op_rs1_data, 32'hA5A5_0005);
        chk("t5_rs2", op_rs2_data, 32'hA5A5_0005);
        wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 32'h0000_5555;
        tick; wb_valid = 1'b0; #1;
        chk("t5_fwd_rs1", op_rs1_data, 32'h0000_5555);
        chk("t5_fwd_rs2", op_rs2_data, 32'h0000_5555);

        // Forward into rs1 while stalled in READ2, then read rs2
        op_ready = 1'b1; request(4'd3, 4'd7, 1'b1);
        tick; op_ready = 1'b0; req_valid = 1'b0;
        tick; #1;
        chk("f_read2_reg", 32'(rb_reg_num), 32'd7);
        wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h0000_1111;
        tick; wb_valid = 1'b0; #1;
        chk("f_read2_stall", 32'(op_valid), 32'd0);
        chk("f_read2_rs1", op_rs1_data, 32'h0000_1111);
        tick;
        chk("f_valid", 32'(op_valid), 32'd1);
        chk("f_rs2", op_rs2_data, 32'h0000_0777);
        wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'h0000_BEEF;
        tick; wb_valid = 1'b0; #1;
        chk("f_fwd_rs2", op_rs2_data, 32'h0000_BEEF);

        // use_rs2=0 with a nonzero rs2: operand forced zero and never forwarded
        op_ready = 1'b1; request(4'd0, 4'd7, 1'b0);
        tick; op_ready = 1'b0; req_valid = 1'b0; #1;
        chk("u_valid", 32'(op_valid), 32'd1);
        chk("u_rs2", op_rs2_data, 32'd0);
        wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'h0000_CAFE;
        tick; wb_valid = 1'b0; #1;
        chk("u_nofwd", op_rs2_data, 32'd0);

        // Test 6: reset during READ2 discards the request
        op_ready = 1'b1; request(4'd5, 4'd7, 1'b1);
        tick; op_ready = 1'b0; req_valid = 1'b0;
        tick; #1;
        chk("t6_in_read2", 32'(rb_reg_num), 32'd7);
        reset = 1'b1;
        tick;
        chk("t6_valid", 32'(op_valid), 32'd0);
        chk("t6_rs1", op_rs1_data, 32'd0);
        chk("t6_rs2", op_rs2_data, 32'd0);
        chk("t6_reg", 32'(rb_reg_num), 32'd0);
        chk("t6_wb_ready", 32'(wb_ready), 32'd0);
        reset = 1'b0; #1;
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        tick;
        chk("t6_no_resume_reg", 32'(rb_reg_num), 32'd0);
        tick;
        chk("t6_no_resume_valid", 32'(op_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
